rr_grant_encoder: RTL and testbench

- 8-way round-robin arbiter that issues a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the 3:8 decoder. gnt_idx drives the decoder's 3-bit select; the decoder's 8-bit one-hot output gated by gnt_valid forms the per-requester grant lines.
- Owns fairness, grant hold/release handshake and optional stuck-grant recovery.

---
 rtl/rr_grant_encoder.sv | 124 ++++++++++++
 tb/tb_rr_grant_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_encoder.sv
// 8-way round-robin arbiter producing a registered 3-bit grant index and valid flag.
// Optional stuck-grant recovery is enabled with `define RR_GRANT_TIMEOUT_EN.
module rr_grant_encoder #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [2:0] gnt_idx_q;
  logic       gnt_valid_q;
  logic [2:0] winner_d;

  if (HOLD_MAX < 2 || HOLD_MAX > 255 || HOLD_MAX >= (1 << HOLD_W)) begin : g_bad_cfg
    $error("rr_grant_encoder: HOLD_MAX must be 2..255 and below 2**HOLD_W");
  end

  // Scan from farthest to nearest offset so the last hit (closest to ptr) wins.
  always_comb begin
    winner_d = ptr_q;
    for (int unsigned k = 0; k < 8; k++) begin
      if (req[ptr_q + 3'(7 - k)]) begin
        winner_d = ptr_q + 3'(7 - k);
      end
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      hold_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_idx_q   <= winner_d;
            gnt_valid_q <= 1'b1;
            hold_q      <= '0;
            state_q     <= GRANT;
          end else begin
            gnt_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (done) begin
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 3'd1;
            state_q     <= IDLE;
          end else if (hold_q == HoldLast) begin
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 3'd1;
            state_q     <= IDLE;
            timeout_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_idx_q   <= winner_d;
            gnt_valid_q <= 1'b1;
            state_q     <= GRANT;
          end else begin
            gnt_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (done) begin
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 3'd1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = gnt_valid_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Scoreboard bench for rr_grant_encoder: per-cycle expected outputs and expected grant order.
`timescale 1ns/1ps
module tb_rr_grant_encoder;

  localparam int unsigned HoldMax = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  logic       timeout;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [5:0] exp_q[$];
  logic [2:0] gnt_q[$];
  bit         auto_grants = 1'b0;
  bit         prev_valid  = 1'b0;

  bit          m_gr;
  logic [2:0]  m_ptr;
  logic [2:0]  m_idx;
  bit          m_valid;
  bit          m_to;
  int unsigned m_hold;

  always #5 clk = ~clk;

  rr_grant_encoder #(
    .HOLD_MAX(HoldMax),
    .HOLD_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .busy     (busy),
    .timeout  (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gr = 1'b0; m_ptr = '0; m_idx = '0; m_valid = 1'b0; m_to = 1'b0; m_hold = 0;
    prev_valid = 1'b0;
  endtask

  task automatic model_release();
    m_valid = 1'b0;
    m_gr    = 1'b0;
    m_ptr   = m_idx + 3'd1;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit found;
    int j;
    m_to = 1'b0;
    if (!m_gr) begin
      if (r != 8'h00) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          j = (int'(m_ptr) + k) % 8;
          if (!found && r[j]) begin
            m_idx = 3'(j);
            found = 1'b1;
          end
        end
        m_valid = 1'b1;
        m_gr    = 1'b1;
        m_hold  = 0;
        if (auto_grants) gnt_q.push_back(m_idx);
      end else begin
        m_valid = 1'b0;
      end
    end else if (d) begin
      model_release();
    end else if (ToEn && m_hold == HoldMax - 1) begin
      model_release();
      m_to = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  // Called at a negedge: drive, predict, clock, then compare at the next negedge.
  task automatic step(input logic [7:0] r, input logic d);
    logic [5:0] e;
    req  = r;
    done = d;
    model_step(r, d);
    exp_q.push_back({m_to, m_valid, m_valid, m_idx});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("cycle{to,busy,vld,idx}", {26'd0, timeout, busy, gnt_valid, gnt_idx}, {26'd0, e});
    if (gnt_valid && !prev_valid) begin
      check("grant_pending", {31'd0, gnt_q.size() > 0}, 32'd1);
      if (gnt_q.size() > 0) check("grant_idx", {29'd0, gnt_idx}, {29'd0, gnt_q.pop_front()});
    end
    prev_valid = gnt_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outs", {28'd0, timeout, busy, gnt_valid, gnt_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int unsigned vcnt;
    int unsigned tcnt;
    rst = 1'b1; req = '0; done = 1'b0;
    model_reset();
    @(negedge clk);

    // Full request load: strict 0..7,0 rotation, one idle cycle between grants.
    do_reset();
    for (int i = 0; i < 9; i++) gnt_q.push_back(3'(i % 8));
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end

    // Wrapping scan from ptr 0 to requester 7, then ptr wraps back to 0.
    do_reset();
    gnt_q.push_back(3'd7);
    gnt_q.push_back(3'd0);
    step(8'h80, 1'b0);
    check("wrap_idx7", {29'd0, gnt_idx}, 32'd7);
    step(8'h80, 1'b1);
    step(8'h81, 1'b0);
    check("wrap_idx0", {29'd0, gnt_idx}, 32'd0);
    step(8'h81, 1'b1);

    // Grant held while requests vanish and done stays low.
    do_reset();
    gnt_q.push_back(3'd3);
    step(8'h08, 1'b0);
    for (int i = 0; i < 50; i++) step(8'h00, 1'b0);
`ifndef RR_GRANT_TIMEOUT_EN
    check("hold_idx", {29'd0, gnt_idx}, 32'd3);
    check("hold_valid", {31'd0, gnt_valid}, 32'd1);
`endif
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

`ifdef RR_GRANT_TIMEOUT_EN
    // Forced release after HOLD_MAX cycles, then immediate re-grant.
    do_reset();
    gnt_q.push_back(3'd2);
    gnt_q.push_back(3'd2);
    vcnt = 0; tcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'h04, 1'b0);
      if (gnt_valid) vcnt++;
      if (timeout) tcnt++;
    end
    check("to_valid_cycles", vcnt, 32'd4);
    check("to_pulses", tcnt, 32'd1);
    step(8'h04, 1'b0);
    check("to_regrant", {30'd0, gnt_valid, timeout}, 32'h2);
    // done on the expiry edge is a normal release.
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    check("to_done_on_expiry", {30'd0, gnt_valid, timeout}, 32'h0);
    step(8'h00, 1'b0);
`else
    vcnt = 0; tcnt = 0;
`endif

    // Asynchronous reset in the middle of a grant.
    do_reset();
    gnt_q.push_back(3'd5);
    gnt_q.push_back(3'd0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, gnt_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_idx", {29'd0, gnt_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b1);

    // Stray done pulses while idle must not move the pointer.
    do_reset();
    gnt_q.push_back(3'd4);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h30, 1'b0);
    check("stray_done_idx", {29'd0, gnt_idx}, 32'd4);
    step(8'h30, 1'b1);

    // Random traffic against the model.
    auto_grants = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
    end

    check("grants_left", gnt_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
